// File: rtl/life_pkg.sv
// Shared types and width helpers for the Game-of-Life frame streaming path.
package life_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    // Largest board the generic row-slice helper can address.
    localparam int MAX_N     = 32;
    localparam int MAX_CELLS = MAX_N * MAX_N;

    function automatic int ROW_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int POP_W(input int n);
        return $clog2(n * n + 1);
    endfunction

    // Row r of an n x n board, row 0 in the top bits; caller truncates to n bits.
    function automatic logic [MAX_N-1:0] row_slice(input logic [MAX_CELLS-1:0] board,
                                                   input int n, input int r);
        return board[n * (n - 1 - r) +: MAX_N];
    endfunction

endpackage

// File: rtl/row_popcount.sv
// Combinational population count of one N-bit board row.
module row_popcount #(
    parameter int N = 16,
    localparam int PW = $clog2(N + 1)
) (
    input  logic [N-1:0]  row,
    output logic [PW-1:0] pop
);

    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++)
            pop = pop + PW'(row[i]);
    end

endmodule

// File: rtl/life_frame_streamer.sv
// Snapshots the life board on start, streams it row by row over valid/ready,
// then reports population and still-life status of the finished frame.
module life_frame_streamer
    import life_pkg::*;
#(
    parameter int N     = 16,
    parameter int CNT_W = 8,
    localparam int IW   = ROW_IDX_W(N),
    localparam int PW   = POP_W(N),
    localparam int RPW  = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N*N-1:0]   cells,
    input  logic             start,
    input  logic             row_ready,
    output logic             row_valid,
    output logic [N-1:0]     row_data,
    output logic [IW-1:0]    row_idx,
    output logic             row_last,
    output logic             frame_done,
    output logic [PW-1:0]    frame_pop,
    output logic             frame_static,
    output logic             busy,
    output logic [CNT_W-1:0] dropped_starts
);

    state_t           state, state_nxt;
    logic [N*N-1:0]   snap, prev_snap;
    logic             have_prev, eq;
    logic [PW-1:0]    pop_acc;
    logic [IW-1:0]    idx;
    logic [N-1:0]     cur_row;
    logic [RPW-1:0]   cur_pop;
    logic             hs, last;

    assign cur_row = N'(row_slice(MAX_CELLS'(snap), N, int'(idx)));
    assign last    = (idx == IW'(N - 1));

    row_popcount #(.N(N)) u_pop (.row(cur_row), .pop(cur_pop));

    always_comb begin
        state_nxt  = state;
        row_valid  = (state == STREAM);
        row_data   = row_valid ? cur_row : '0;
        row_idx    = idx;
        row_last   = row_valid && last;
        frame_done = (state == DONE);
        busy       = (state != IDLE);
        hs         = row_valid && row_ready;
        case (state)
            IDLE:    if (start)      state_nxt = STREAM;
            STREAM:  if (hs && last) state_nxt = DONE;
            DONE:                    state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            snap           <= '0;
            prev_snap      <= '0;
            have_prev      <= 1'b0;
            eq             <= 1'b0;
            pop_acc        <= '0;
            idx            <= '0;
            frame_pop      <= '0;
            frame_static   <= 1'b0;
            dropped_starts <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                snap    <= cells;
                idx     <= '0;
                pop_acc <= '0;
                eq      <= have_prev && (cells == prev_snap);
            end
            if (hs) begin
                pop_acc <= pop_acc + PW'(cur_pop);
                if (!last) begin
                    idx <= idx + 1'b1;
                end else begin
                    // Results land on the edge entering DONE so they align with frame_done.
                    frame_pop    <= pop_acc + PW'(cur_pop);
                    frame_static <= eq;
                    prev_snap    <= snap;
                    have_prev    <= 1'b1;
                end
            end
            if (start && state != IDLE && dropped_starts != '1)
                dropped_starts <= dropped_starts + 1'b1;
        end
    end

endmodule

// File: tb/tb_life_frame_streamer.sv
// Directed bench for life_frame_streamer: glider, still life, backpressure,
// dropped starts, mid-frame reset and extreme boards.
module tb_life_frame_streamer;

    localparam int N = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           row_ready = 1'b0;
    logic [N*N-1:0] cells = '0;
    logic           row_valid, row_last, frame_done, frame_static, busy;
    logic [N-1:0]   row_data;
    logic [3:0]     row_idx;
    logic [8:0]     frame_pop;
    logic [7:0]     dropped_starts;

    life_frame_streamer #(.N(N), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cells(cells), .start(start), .row_ready(row_ready),
        .row_valid(row_valid), .row_data(row_data), .row_idx(row_idx), .row_last(row_last),
        .frame_done(frame_done), .frame_pop(frame_pop), .frame_static(frame_static),
        .busy(busy), .dropped_starts(dropped_starts)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] got [16];
    logic [15:0] exp_rows [16];
    int   hs_cnt, bad_hold, bad_last, bad_idx, lat;
    logic first_valid, done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_board();
        cells = '0;
        for (int r = 0; r < N; r++)
            cells[N*(N-1-r) +: N] = exp_rows[r];
    endtask

    task automatic set_rows(input logic [15:0] fill);
        for (int r = 0; r < N; r++)
            exp_rows[r] = fill;
    endtask

    // bp: 0 always ready, 1 ready pattern 1,0,0,..., 2 stall ~320 cycles.
    // drop_mode: 0 none, 1 three start pulses mid-stream, 2 start held for 300 cycles.
    task automatic run_frame(input int bp, input int drop_mode, input bit scramble);
        logic [N*N-1:0] saved;
        logic           held;
        logic [15:0]    hd;
        logic [3:0]     hi;
        saved = cells;
        hs_cnt = 0; bad_hold = 0; bad_last = 0; bad_idx = 0; lat = 0;
        done_seen = 1'b0; first_valid = 1'b0; held = 1'b0; hd = '0; hi = '0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 400 && !done_seen; k++) begin
            @(negedge clk);
            start = (drop_mode == 1 && (k == 2 || k == 4 || k == 6)) ||
                    (drop_mode == 2 && k >= 1 && k <= 300);
            row_ready = (bp == 0) ? 1'b1 : (bp == 1) ? (k % 3 == 0) : (k >= 320);
            if (scramble && k == 0) cells = ~cells;
            #1;
            if (k == 0) first_valid = row_valid;
            if (frame_done) begin
                done_seen = 1'b1;
                lat = k + 1;
            end else if (row_valid) begin
                if (held && (row_data !== hd || row_idx !== hi)) bad_hold++;
                if (row_last !== (row_idx == 4'd15)) bad_last++;
                if (row_ready) begin
                    if (hs_cnt < 16) got[hs_cnt] = row_data;
                    if (row_idx !== 4'(hs_cnt)) bad_idx++;
                    hs_cnt++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    hd = row_data;
                    hi = row_idx;
                end
            end
        end
        start = 1'b0;
        row_ready = 1'b1;
        cells = saved;
        chk("frame_done_seen", 32'(done_seen), 32'd1);
    endtask

    task automatic chk_rows(input string pre);
        for (int r = 0; r < N; r++)
            chk($sformatf("%s_row%0d", pre, r), 32'(got[r]), 32'(exp_rows[r]));
        chk({pre, "_handshakes"}, hs_cnt, 16);
        chk({pre, "_hold"}, bad_hold, 0);
        chk({pre, "_last"}, bad_last, 0);
        chk({pre, "_idx"}, bad_idx, 0);
    endtask

    task automatic check_zero(input string pre);
        chk({pre, "_row_valid"}, 32'(row_valid), 0);
        chk({pre, "_row_data"}, 32'(row_data), 0);
        chk({pre, "_row_idx"}, 32'(row_idx), 0);
        chk({pre, "_row_last"}, 32'(row_last), 0);
        chk({pre, "_frame_done"}, 32'(frame_done), 0);
        chk({pre, "_frame_pop"}, 32'(frame_pop), 0);
        chk({pre, "_frame_static"}, 32'(frame_static), 0);
        chk({pre, "_busy"}, 32'(busy), 0);
        chk({pre, "_dropped"}, 32'(dropped_starts), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        row_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Glider; cells are inverted right after capture to prove the snapshot holds.
        set_rows(16'h0000);
        exp_rows[0] = 16'h4000; exp_rows[1] = 16'h2000; exp_rows[2] = 16'hE000;
        load_board();
        run_frame(0, 0, 1'b1);
        chk_rows("glider");
        chk("glider_first_valid", 32'(first_valid), 1);
        chk("glider_latency", lat, 17);
        chk("glider_pop", 32'(frame_pop), 5);
        chk("glider_static", 32'(frame_static), 0);
        chk("glider_dropped", 32'(dropped_starts), 0);

        // 2x2 block at rows 4-5, columns 3-4 (bits 12 and 11).
        set_rows(16'h0000);
        exp_rows[4] = 16'h1800; exp_rows[5] = 16'h1800;
        load_board();
        run_frame(0, 0, 1'b0);
        chk("block1_pop", 32'(frame_pop), 4);
        chk("block1_static", 32'(frame_static), 0);
        run_frame(0, 0, 1'b0);
        chk_rows("block2");
        chk("block2_pop", 32'(frame_pop), 4);
        chk("block2_static", 32'(frame_static), 1);

        // Backpressure with three dropped starts mid-stream: 16 + 8 + 2 live cells.
        set_rows(16'h0000);
        exp_rows[0] = 16'hFFFF; exp_rows[5] = 16'h0F0F; exp_rows[15] = 16'h8001;
        load_board();
        run_frame(1, 1, 1'b0);
        chk_rows("bp");
        chk("bp_pop", 32'(frame_pop), 26);
        chk("bp_static", 32'(frame_static), 0);
        chk("bp_dropped", 32'(dropped_starts), 3);

        // Long stall with start held: counter saturates, frame unaffected.
        run_frame(2, 2, 1'b0);
        chk_rows("sat");
        chk("sat_dropped", 32'(dropped_starts), 255);
        chk("sat_pop", 32'(frame_pop), 26);
        chk("sat_static", 32'(frame_static), 1);

        // Mid-frame reset on the block board, which was streamed before.
        set_rows(16'h0000);
        exp_rows[4] = 16'h1800; exp_rows[5] = 16'h1800;
        load_board();
        row_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (row_idx == 4'd7) break;
            @(negedge clk);
        end
        chk("midrst_idx_reached", 32'(row_idx), 7);
        reset = 1'b0;
        #1;
        check_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(frame_done), 0);
        end
        reset = 1'b1;
        run_frame(0, 0, 1'b0);
        chk("post_rst_pop", 32'(frame_pop), 4);
        chk("post_rst_static", 32'(frame_static), 0);
        run_frame(0, 0, 1'b0);
        chk("post_rst2_static", 32'(frame_static), 1);

        // Extremes.
        set_rows(16'h0000);
        load_board();
        run_frame(0, 0, 1'b0);
        chk("zero_pop", 32'(frame_pop), 0);
        chk("zero_static", 32'(frame_static), 0);
        set_rows(16'hFFFF);
        load_board();
        run_frame(0, 0, 1'b0);
        chk_rows("ones");
        chk("ones_pop", 32'(frame_pop), 256);

        // start presented during the DONE cycle is dropped, not queued.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("done_start_busy", 32'(busy), 0);
        chk("done_start_dropped", 32'(dropped_starts), 1);
        chk("done_start_pop_hold", 32'(frame_pop), 256);
        repeat (2) @(negedge clk);
        chk("done_start_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/life_frame_streamer.md
# life_frame_streamer

Downstream consumer of the Game-of-Life core. Takes one snapshot of the flat N×N `cells` board on a `start` strobe and streams it out one row per valid/ready handshake, top row first. At frame end it reports the live-cell population and whether the board is unchanged from the previous streamed frame (still-life detection). It is the path from the core to display, UART and logging sinks.

## Interface
- `N`, 16: board edge; `cells` is N*N bits.
- `CNT_W`, 8: width of the saturating `dropped_starts` counter.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cells`  in  N*N  live board from the core; row r occupies bits [N*(N-r)-1 : N*(N-1-r)]; bit N-1 of each row is the leftmost column.
- `start`  in  1  request a snapshot; sampled every cycle.
- `row_ready`  in  1  sink accepts the current row.
- `row_valid`  out  1  `row_data` is valid.
- `row_data`  out  N  current row, same bit order as `cells`.
- `row_idx`  out  $clog2(N)  index of the current row, 0 = top.
- `row_last`  out  1  current row is row N-1.
- `frame_done`  out  1  one-cycle pulse after the last row is accepted.
- `frame_pop`  out  $clog2(N*N+1)  live-cell count of the last completed frame.
- `frame_static`  out  1  last completed frame equals the frame before it.
- `busy`  out  1  state is not IDLE.
- `dropped_starts`  out  CNT_W  count of ignored `start` pulses; saturating.

## Operation
- States: IDLE, STREAM, DONE.
- **IDLE, on `start`:**
  - `snap <= cells`; `row_idx <= 0`; `pop_acc <= 0`; go to STREAM.
  - Latch `eq <= have_prev && (cells == prev_snap)`.
- **STREAM:**
  - `row_valid` = 1; `row_data` = row `row_idx` of `snap`.
  - On `row_valid && row_ready`: `pop_acc += popcount(row)`.
    - If `row_idx == N-1`, go to DONE; otherwise `row_idx` increments.
  - While `row_ready` = 0, `row_data`, `row_idx` and `row_last` hold stable.
- **DONE (one cycle):**
  - `frame_done` = 1.
  - `frame_pop <= pop_acc` (final value, last row included); `frame_static <= eq`.
  - `prev_snap <= snap`; `have_prev <= 1`; go to IDLE.
- **Dropped starts:** `start` while in STREAM or DONE is ignored and increments `dropped_starts`, saturating at 2^CNT_W-1.
- **Frame results:** `frame_pop` and `frame_static` hold until the next DONE.
- **Width rules:**
  - Row popcount is $clog2(N+1) bits.
  - The accumulator is $clog2(N*N+1) bits, so no overflow is possible; an all-ones board gives N*N.

## Timing
- **Reset values:** `reset` low immediately forces:
  - state IDLE;
  - `row_valid`, `row_data`, `row_idx`, `row_last`, `frame_done`, `frame_pop`, `frame_static`, `busy`, `dropped_starts` = 0;
  - `have_prev` = 0, `prev_snap` = 0.
- **Start latency:** `start` sampled at edge t gives `row_valid` = 1 with row 0 in cycle t+1. `cells` is captured at edge t; later core updates do not affect the frame.
- **Frame length:** minimum frame is N accepted rows plus 1 DONE cycle. A new `start` is accepted at the first IDLE cycle after DONE.
- **Frame results:** `frame_done`, `frame_pop` and `frame_static` all update at the same edge.
- **First frame after reset:** `frame_static` = 0.
- **Reset mid-frame:** the frame is abandoned with no `frame_done`. `have_prev` clears, so the next frame's `frame_static` = 0.
- **`start` on the DONE cycle:** dropped and counted; the next IDLE cycle must see `start` again.

## Structure
- Package `life_pkg`:
  - state enum (IDLE/STREAM/DONE);
  - width helpers `ROW_IDX_W(N)`, `POP_W(N)`;
  - row-slice helper that returns row r of a flat board.
- Sub-module `row_popcount #(N)`: combinational N-bit population count, reused by later stages.
- The remainder is one FSM plus datapath registers, about 200 lines.

## Test plan
- **Glider:** N=16, `cells` rows 0–2 = 0100…, 0010…, 1110…, rest 0; pulse `start`, `row_ready` held 1.
  - Rows stream as 0x4000, 0x2000, 0xE000, then 13×0x0000.
  - `row_last` is set only at idx 15; `frame_done` is 17 cycles after `start`.
  - `frame_pop` = 5, `frame_static` = 0.
- **Still life:** 2×2 block at rows 4–5, columns 3–4; stream it twice.
  - Frame 1: `frame_static` = 0, `frame_pop` = 4.
  - Frame 2: `frame_static` = 1.
- **Backpressure:** `row_ready` toggles 1,0,0,1… → each row is held stable while not ready; total handshakes = 16; `frame_pop` is correct.
- **Dropped starts:** pulse `start` 3 times during STREAM → `dropped_starts` = 3 and the frame is unaffected. Then force 300 dropped starts → `dropped_starts` saturates at 255.
- **Reset mid-frame:** assert `reset` low at row 7 → outputs go to 0 immediately with no `frame_done`. The next frame of the same board reports `frame_static` = 0.
- **Extremes:** all-zero board → `frame_pop` = 0; all-ones board → `frame_pop` = 256.
